// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int BE_W       = 4;
  localparam int WORD_BYTES = 4;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the core memory stage and the responder.
interface dmem_if;
  import dmem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic            req_we;
  logic [31:0]     req_wdata;
  logic [BE_W-1:0] req_be;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_bank.sv
// Word array with byte-enabled synchronous write and combinational read.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [BE_W-1:0]                be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and registered responses.
// Optional access statistics counters are enabled by defining DMEM_STATS_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_if.slave             bus
`ifdef DMEM_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errs
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic            ready_q;
  logic            valid_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [31:0]     cap_addr;
  logic [31:0]     cap_wdata;
  logic            cap_we;
  logic [BE_W-1:0] cap_be;

  logic            accept;
  logic            acc_now;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic            acc_we;
  logic [BE_W-1:0] acc_be;
  logic            acc_err;
  logic [31:0]     bank_rdata;

  function automatic logic addr_err(input logic [31:0] a);
    return ((a & 32'(WORD_BYTES - 1)) != 32'd0) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  assign accept = bus.req_valid && ready_q;

  // With zero wait states the access uses the request as it is being accepted.
  always_comb begin
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_we    = cap_we;
    acc_be    = cap_be;
    acc_now   = 1'b0;
    if (state == IDLE) begin
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_we    = bus.req_we;
      acc_be    = bus.req_be;
      acc_now   = accept && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      acc_now   = (wait_cnt == 4'd0);
    end
  end

  assign acc_err = addr_err(acc_addr);

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (clk),
    .we    (acc_now && acc_we && !acc_err),
    .be    (acc_be),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
      cap_we    <= bus.req_we;
      cap_be    <= bus.req_be;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state   <= RESP;
              valid_q <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state   <= RESP;
            valid_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          // req_ready comes back one cycle after the response handshake.
          if (bus.rsp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (acc_now) begin
        rdata_q <= (acc_err || acc_we) ? 32'd0 : bank_rdata;
        err_q   <= acc_err;
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

`ifdef DMEM_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (acc_now) begin
      if (acc_err)     stat_errs   <= sat_inc(stat_errs);
      else if (acc_we) stat_stores <= sat_inc(stat_stores);
      else             stat_loads  <= sat_inc(stat_loads);
    end
  end
`endif

endmodule
